// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, line levels and
// the default frame parameters.
package uart_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam bit DEF_PARITY_EN    = 1'b0;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the UART transmitter and its upstream FIFO.
// The transmitter pops (master); the FIFO answers with data and empty (slave).
interface fifo_uart_tx_if
    import uart_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; clear restarts the
// period at 0. tick is registered and is high exactly while the count sits at
// CLKS_PER_BIT-1, i.e. on the last cycle of each serial bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count;

    // Advance the bit-period count and precompute tick for the next cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count + 1'b1;
            tick  <= (count == PRE_LAST);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from an upstream FIFO. Pops one word per frame, sends
// start bit, WIDTH data bits LSB first, optional even parity, and a stop bit.
// Frames run back to back while the FIFO has data.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit PARITY_EN    = DEF_PARITY_EN
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);

    localparam int             BCW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    uart_state_e      state;
    uart_state_e      state_next;
    logic [WIDTH-1:0] shift_reg;
    logic             parity_bit;
    logic [BCW-1:0]   bit_cnt;
    logic             tick;
    logic             clear;

    // Every state entry restarts the bit period from zero.
    assign clear = (state_next != state);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    // Next-state decode; fifo_empty is consulted only in IDLE and on the last STOP cycle.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo.fifo_empty) state_next = POP;
            POP:     state_next = LOAD;
            LOAD:    state_next = START;
            START:   if (tick) state_next = DATA;
            DATA:    if (tick && (bit_cnt == LAST_BIT)) state_next = PARITY_EN ? PARITY : STOP;
            PARITY:  if (tick) state_next = STOP;
            STOP:    if (tick) state_next = fifo.fifo_empty ? IDLE : POP;
            default: state_next = IDLE;
        endcase
    end

    // State register, datapath and registered outputs; tx lags the state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            shift_reg       <= '0;
            parity_bit      <= 1'b0;
            bit_cnt         <= '0;
            tx              <= STOP_BIT;
            busy            <= 1'b0;
            fifo.fifo_rd_en <= 1'b0;
        end else begin
            state           <= state_next;
            fifo.fifo_rd_en <= (state_next == POP);
            busy            <= (state_next != IDLE);

            case (state)
                LOAD: begin
                    shift_reg  <= fifo.fifo_data;
                    parity_bit <= ^fifo.fifo_data;
                    bit_cnt    <= '0;
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            case (state)
                START:   tx <= START_BIT;
                DATA:    tx <= shift_reg[0];
                PARITY:  tx <= parity_bit;
                default: tx <= STOP_BIT;
            endcase
        end
    end

    // Pulse on the final stop-bit cycle, aligned with the STOP state.
    assign frame_done = (state == STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances at CLKS_PER_BIT=4, one without and one
// with parity. Words fed into a FIFO model are also pushed to a scoreboard; a
// line receiver on dut0 decodes tx and compares against the scoreboard.
module tb_fifo_uart_tx;

    localparam int WIDTH      = 8;
    localparam int CPB        = 4;
    localparam int FRAME0     = 2 + (2 + WIDTH) * CPB;   // 42
    localparam int FRAME1     = 2 + (3 + WIDTH) * CPB;   // 46
    localparam int RX_SAMPLES = (2 + WIDTH) * CPB;       // line samples per frame, no parity

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx0, busy0, done0;
    logic tx1, busy1, done1;

    fifo_uart_tx_if #(.WIDTH(WIDTH)) if0 ();
    fifo_uart_tx_if #(.WIDTH(WIDTH)) if1 ();

    fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .fifo(if0), .tx(tx0), .busy(busy0), .frame_done(done0)
    );

    fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .fifo(if1), .tx(tx1), .busy(busy1), .frame_done(done1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] fifo_q0[$];
    logic [WIDTH-1:0] fifo_q1[$];
    logic [WIDTH-1:0] exp_q0[$];

    bit toggle_en  = 1'b0;
    bit gap_track  = 1'b0;
    int empty_pops = 0;
    int unexpected = 0;

    int cyc_cnt       = 0;
    int pop_cyc       = 0;
    int pop_count     = 0;
    int done_count    = 0;
    int pops_in_frame = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model for dut0: a pop seen in the POP cycle presents the word before LOAD.
    always @(negedge clk) begin : fifo0_model
        if (!reset && if0.fifo_rd_en) begin
            if (fifo_q0.size() > 0) if0.fifo_data = fifo_q0.pop_front();
            else empty_pops++;
        end
        if0.fifo_empty = (fifo_q0.size() == 0) || (toggle_en && ($urandom_range(0, 1) == 1));
    end

    // FIFO model for dut1.
    always @(negedge clk) begin : fifo1_model
        if (!reset && if1.fifo_rd_en) begin
            if (fifo_q1.size() > 0) if1.fifo_data = fifo_q1.pop_front();
            else empty_pops++;
        end
        if1.fifo_empty = (fifo_q1.size() == 0);
    end

    // dut0 pop/frame_done monitor: frame length and one pop per frame.
    always @(negedge clk) begin : evt0_mon
        cyc_cnt++;
        if (reset) begin
            pops_in_frame = 0;
        end else begin
            if (if0.fifo_rd_en) begin
                pop_count++;
                pops_in_frame++;
                pop_cyc = cyc_cnt;
            end
            if (done0) begin
                done_count++;
                check("frame_len", 32'(cyc_cnt - pop_cyc + 1), 32'(FRAME0));
                check("pops_in_frame", 32'(pops_in_frame), 32'd1);
                pops_in_frame = 0;
            end
        end
    end

    // dut0 line receiver: every bit must hold CPB samples; word goes to the scoreboard.
    int               rx_cyc      = 0;
    int               idle_run    = 0;
    bit               rx_busy     = 1'b0;
    bit               rx_shape_ok = 1'b1;
    bit               have_prev   = 1'b0;
    logic             rx_bit;
    logic [WIDTH-1:0] rx_word;

    always @(negedge clk) begin : rx0_mon
        int slot;
        int phase;
        if (reset) begin
            rx_busy  = 1'b0;
            idle_run = 0;
        end else if (!rx_busy) begin
            if (!gap_track) have_prev = 1'b0;
            if (tx0 === 1'b0) begin
                if (gap_track && have_prev) check("b2b_gap", 32'(idle_run), 32'd2);
                rx_busy     = 1'b1;
                rx_cyc      = 1;
                rx_bit      = 1'b0;
                rx_word     = '0;
                rx_shape_ok = 1'b1;
            end else begin
                idle_run++;
            end
        end else begin
            slot  = rx_cyc / CPB;
            phase = rx_cyc % CPB;
            if (phase == 0) begin
                rx_bit = tx0;
                if (slot >= 1 && slot <= WIDTH) rx_word[slot-1] = tx0;
                if (slot == WIDTH + 1 && tx0 !== 1'b1) rx_shape_ok = 1'b0;
            end else if (tx0 !== rx_bit) begin
                rx_shape_ok = 1'b0;
            end
            if (rx_cyc == RX_SAMPLES - 1) begin
                check("rx_shape", 32'(rx_shape_ok), 32'd1);
                if (exp_q0.size() > 0) check("rx_word", 32'(rx_word), 32'(exp_q0.pop_front()));
                else unexpected++;
                rx_busy   = 1'b0;
                have_prev = 1'b1;
                idle_run  = 0;
            end
            rx_cyc++;
        end
    end

    task automatic send0(input logic [WIDTH-1:0] w);
        fifo_q0.push_back(w);
        exp_q0.push_back(w);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(done_count >= target), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // One parity frame on dut1: decode data, parity bit and frame length by cycle offset.
    task automatic parity_frame(input logic [WIDTH-1:0] w);
        int               n;
        int               len;
        logic             par;
        logic [WIDTH-1:0] got;
        fifo_q1.push_back(w);
        n = 0;
        while (!if1.fifo_rd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("p_pop_seen", 32'(if1.fifo_rd_en), 32'd1);
        len = 0;
        par = 1'b0;
        got = '0;
        for (int c = 2; c <= 80; c++) begin
            @(negedge clk);
            if (c >= 9 && c < 9 + CPB * WIDTH && ((c - 9) % CPB) == 0) got[(c - 9) / CPB] = tx1;
            if (c == 9 + CPB * WIDTH) par = tx1;
            if (done1) begin
                len = c;
                break;
            end
        end
        check("p_word", 32'(got), 32'(w));
        check("p_parity", 32'(par), 32'(^w));
        check("p_frame_len", 32'(len), 32'(FRAME1));
        repeat (4) @(negedge clk);
    endtask

    initial begin : stimulus
        int n;
        int bad_rd;
        int bad_tx;
        int bad_busy;
        int pops_base;
        int done_base;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx0", 32'(tx0), 32'd1);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_rd_en0", 32'(if0.fifo_rd_en), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_tx1", 32'(tx1), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single word, no parity.
        send0(8'hA5);
        wait_done(done_count + 1, 200);

        // Parity instance: odd and even number of ones.
        parity_frame(8'h07);
        parity_frame(8'h03);

        // Three queued words must go out back to back.
        gap_track = 1'b1;
        send0(8'h01);
        send0(8'h80);
        send0(8'hFF);
        wait_done(done_count + 3, 400);
        gap_track = 1'b0;

        // Empty FIFO held: the line stays idle.
        bad_rd   = 0;
        bad_tx   = 0;
        bad_busy = 0;
        repeat (100) begin
            @(negedge clk);
            if (if0.fifo_rd_en !== 1'b0) bad_rd++;
            if (tx0 !== 1'b1) bad_tx++;
            if (busy0 !== 1'b0) bad_busy++;
        end
        check("idle_rd_en", 32'(bad_rd), 32'd0);
        check("idle_tx", 32'(bad_tx), 32'd0);
        check("idle_busy", 32'(bad_busy), 32'd0);

        // Reset during data bit 3 aborts the frame; the popped word is lost.
        send0(8'hC3);
        n = 0;
        while (!if0.fifo_rd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_pop_seen", 32'(if0.fifo_rd_en), 32'd1);
        repeat (19) @(negedge clk);
        check("rst_pre_tx", 32'(tx0), 32'd0);
        check("rst_pre_busy", 32'(busy0), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", 32'(tx0), 32'd1);
        check("rst_mid_busy", 32'(busy0), 32'd0);
        check("rst_mid_rd_en", 32'(if0.fifo_rd_en), 32'd0);
        check("rst_mid_done", 32'(done0), 32'd0);
        exp_q0.delete();
        reset = 1'b0;
        @(negedge clk);
        send0(8'h5A);
        wait_done(done_count + 1, 200);

        // fifo_empty toggling mid-frame must not cause extra pops.
        pops_base = pop_count;
        done_base = done_count;
        toggle_en = 1'b1;
        send0(8'h5C);
        send0(8'h33);
        send0(8'hE1);
        wait_done(done_base + 3, 1500);
        toggle_en = 1'b0;
        repeat (20) @(negedge clk);
        check("tog_pops", 32'(pop_count - pops_base), 32'd3);
        check("tog_dones", 32'(done_count - done_base), 32'd3);

        // End-of-run bookkeeping: one aborted frame accounts for the extra pop.
        check("empty_pops", 32'(empty_pops), 32'd0);
        check("unexpected_frames", 32'(unexpected), 32'd0);
        check("scoreboard_drained", 32'(exp_q0.size()), 32'd0);
        check("pops_vs_dones", 32'(pop_count), 32'(done_count + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
